// File: rtl/vga_timing_pkg.sv
// Shared types and 640x480@60 default timing for the raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, both
// stepped together on 'adv'; 'wrap' flags the last position of the axis.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0,
  parameter int   CNT_W  = 10
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             wrap,
  output logic             active_next
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_field
    $error("vga_axis_counter: every timing field must be >= 1");
  end
  if (TOTAL - 1 >= (2 ** CNT_W)) begin : g_bad_width
    $error("vga_axis_counter: CNT_W too narrow for the axis total");
  end

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  phase_e           phase_reg, phase_next;
  logic             sync_reg, sync_next;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= LAST;
      phase_reg <= PH_BACK;
      sync_reg  <= ~POL;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      sync_reg  <= sync_next;
    end
  end

  assign wrap = (cnt_reg == LAST);

  // Phase moves on the same step that crosses its boundary, so syncs never lag the count.
  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (adv) begin
      cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);
      case (phase_reg)
        PH_ACTIVE: if (cnt_reg == LAST_ACT)  phase_next = PH_FRONT;
        PH_FRONT:  if (cnt_reg == LAST_FP)   phase_next = PH_SYNC;
        PH_SYNC:   if (cnt_reg == LAST_SYNC) phase_next = PH_BACK;
        PH_BACK:   if (wrap)                 phase_next = PH_ACTIVE;
        default:                             phase_next = PH_BACK;
      endcase
    end
    sync_next   = (phase_next == PH_SYNC) ? POL : ~POL;
    active_next = (phase_next == PH_ACTIVE);
  end

  assign cnt  = cnt_reg;
  assign sync = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered, mutually aligned coordinates, syncs and strobes.
// Optional frame counter built only when VTG_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CNT_W    = 10,
  parameter int   FRAME_W  = 8
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               ce,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_active,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  logic h_wrap, v_wrap, h_active_next, v_active_next, v_adv;
  logic video_active_reg, line_start_reg, frame_start_reg;
  logic line_start_next, frame_start_next;

  assign v_adv = ce & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .adv        (ce),
    .cnt        (pixel_x),
    .sync       (hsync),
    .wrap       (h_wrap),
    .active_next(h_active_next)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .adv        (v_adv),
    .cnt        (pixel_y),
    .sync       (vsync),
    .wrap       (v_wrap),
    .active_next(v_active_next)
  );

  // Strobes derive from the step being taken, so they drop on any edge without ce.
  assign line_start_next  = ce & h_wrap;
  assign frame_start_next = ce & h_wrap & v_wrap;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      video_active_reg <= 1'b0;
      line_start_reg   <= 1'b0;
      frame_start_reg  <= 1'b0;
    end else begin
      video_active_reg <= h_active_next & v_active_next;
      line_start_reg   <= line_start_next;
      frame_start_reg  <= frame_start_next;
    end
  end

  assign video_active = video_active_reg;
  assign line_start   = line_start_reg;
  assign frame_start  = frame_start_reg;

`ifdef VTG_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_reg;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
    end else if (frame_start_next) begin
      frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_reg;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing instance plus a tiny 7x5 instance for
// whole-frame, polarity and frame counter behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VTG_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic       rst0_n, ce0, rst1_n, ce1;
  logic [9:0] x0, y0;
  logic       hs0, vs0, va0, ls0, fs0;
  logic [7:0] fc0;
  logic [2:0] x1, y1;
  logic       hs1, vs1, va1, ls1, fs1;
  logic [1:0] fc1;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen dut0 (
    .clk_pix(clk), .rst_n(rst0_n), .ce(ce0),
    .pixel_x(x0), .pixel_y(y0), .hsync(hs0), .vsync(vs0),
    .video_active(va0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(3), .FRAME_W(2)
  ) dut1 (
    .clk_pix(clk), .rst_n(rst1_n), .ce(ce1),
    .pixel_x(x1), .pixel_y(y1), .hsync(hs1), .vsync(vs1),
    .video_active(va1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
    $display("check %-18s observed=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_x"}, 32'(x0), 799);
    chk({tag, "_y"}, 32'(y0), 524);
    chk({tag, "_va"}, 32'(va0), 0);
    chk({tag, "_hs"}, 32'(hs0), 1);
    chk({tag, "_vs"}, 32'(vs0), 1);
    chk({tag, "_ls"}, 32'(ls0), 0);
    chk({tag, "_fs"}, 32'(fs0), 0);
  endtask

  initial begin
    int ex, ey, bad, hlow, first_low, nls, ls_a, ls_b, efc, nfs, fs_last, fs_gap, hhi, vhi;
    logic exp_hs;

    rst0_n = 1'b0; rst1_n = 1'b0; ce0 = 1'b1; ce1 = 1'b1;
    repeat (3) tick();
    chk_reset0("rst0");
    chk("rst0_fc", 32'(fc0), 0);

    // First ce after reset lands on (0,0) with both strobes
    rst0_n = 1'b1;
    tick();
    chk("first_x", 32'(x0), 0);
    chk("first_y", 32'(y0), 0);
    chk("first_va", 32'(va0), 1);
    chk("first_ls", 32'(ls0), 1);
    chk("first_fs", 32'(fs0), 1);
    chk("first_hs", 32'(hs0), 1);

    // One full line at ce=1
    ex = 0; ey = 0; bad = 0; hlow = 0; first_low = -1; nls = 0; ls_a = -1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      ex++;
      if (ex == 800) begin ex = 0; ey++; end
      exp_hs = !(ex >= 656 && ex < 752);
      if (x0 !== 10'(ex) || y0 !== 10'(ey) || hs0 !== exp_hs || vs0 !== 1'b1 ||
          va0 !== (ex < 640) || ls0 !== (ex == 0) || fs0 !== 1'b0) bad++;
      if (!hs0) begin
        hlow++;
        if (first_low < 0) first_low = int'(x0);
      end
      if (ls0) begin nls++; ls_a = i; end
    end
    chk("line_scan_errs", 32'(bad), 0);
    chk("hsync_low_clks", 32'(hlow), 96);
    chk("hsync_first_low", 32'(first_low), 656);
    chk("line_starts", 32'(nls), 1);
    chk("line_period", 32'(ls_a), 800);

    // ce toggling 1,0: outputs frozen on ce=0 cycles, strobes one clock wide
    bad = 0; nls = 0; ls_a = -1; ls_b = -1;
    for (int i = 0; i < 3200; i++) begin
      ce0 = (i % 2 == 0);
      tick();
      if (ce0) begin
        ex++;
        if (ex == 800) begin ex = 0; ey++; end
      end
      exp_hs = !(ex >= 656 && ex < 752);
      if (x0 !== 10'(ex) || y0 !== 10'(ey) || hs0 !== exp_hs || va0 !== (ex < 640) ||
          ls0 !== (ce0 && ex == 0) || fs0 !== 1'b0) bad++;
      if (ls0) begin
        nls++;
        ls_a = ls_b;
        ls_b = i;
      end
    end
    chk("ce_half_errs", 32'(bad), 0);
    chk("ce_half_lstarts", 32'(nls), 2);
    chk("ce_half_period", 32'(ls_b - ls_a), 1600);
    chk("ce_half_y", 32'(y0), 3);

    // Mid-line reset takes effect without waiting for a clock edge
    ce0 = 1'b1;
    repeat (300) tick();
    chk("pre_rst_x", 32'(x0), 300);
    rst0_n = 1'b0;
    #1;
    chk_reset0("async_rst");
    tick();
    rst0_n = 1'b1; ce0 = 1'b0;
    tick();
    chk_reset0("hold_ce0");
    ce0 = 1'b1;
    tick();
    chk("restart_x", 32'(x0), 0);
    chk("restart_y", 32'(y0), 0);
    chk("restart_fs", 32'(fs0), 1);
    chk("restart_ls", 32'(ls0), 1);
    chk("restart_fc", 32'(fc0), FC_EN ? 1 : 0);
    tick();
    chk("restart_fs_drop", 32'(fs0), 0);
    chk("restart_x1", 32'(x0), 1);

    // Tiny timing: H 4/1/1/1, V 2/1/1/1, active-high syncs
    chk("tiny_rst_x", 32'(x1), 6);
    chk("tiny_rst_y", 32'(y1), 4);
    chk("tiny_rst_hs", 32'(hs1), 0);
    chk("tiny_rst_vs", 32'(vs1), 0);
    chk("tiny_rst_fc", 32'(fc1), 0);
    rst1_n = 1'b1;
    tick();
    chk("tiny_first_fs", 32'(fs1), 1);
    chk("tiny_first_va", 32'(va1), 1);
    chk("tiny_first_fc", 32'(fc1), FC_EN ? 1 : 0);

    ex = 0; ey = 0; bad = 0; efc = FC_EN ? 1 : 0; nfs = 0; fs_last = 0; fs_gap = 0;
    hhi = 0; vhi = 0;
    for (int i = 1; i <= 140; i++) begin
      tick();
      ex++;
      if (ex == 7) begin
        ex = 0;
        ey++;
        if (ey == 5) ey = 0;
      end
      if (x1 !== 3'(ex) || y1 !== 3'(ey) || hs1 !== (ex == 5) || vs1 !== (ey == 3) ||
          va1 !== (ex < 4 && ey < 2) || ls1 !== (ex == 0) || fs1 !== (ex == 0 && ey == 0)) bad++;
      if (hs1) hhi++;
      if (vs1) vhi++;
      if (ex == 0 && ey == 0) begin
        efc = FC_EN ? (efc + 1) % 4 : 0;
        chk("tiny_frame_cnt", 32'(fc1), 32'(efc));
        nfs++;
        fs_gap = i - fs_last;
        fs_last = i;
      end
    end
    chk("tiny_scan_errs", 32'(bad), 0);
    chk("tiny_hsync_clks", 32'(hhi), 20);
    chk("tiny_vsync_clks", 32'(vhi), 28);
    chk("tiny_frames", 32'(nfs), 4);
    chk("tiny_frame_period", 32'(fs_gap), 35);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
